// File: rtl/mem_bank_responder.sv
// mem_bank_responder: far end of the crossbar's four-phase req/ack handshake.
// Holds one vector memory bank and services one read or write per handshake
// after a fixed access latency. It also keeps access counters and a sticky
// protocol-error flag.
module mem_bank_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqMEM,
    input  logic                  rwMEM,
    input  logic [DEPTH_LOG2-1:0] addrMEM,
    input  logic [WIDTH-1:0]      dinMEM,
    output logic                  ackMEM,
    output logic [WIDTH-1:0]      doutMEM,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  proto_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // LATENCY is limited to 1..15, so a 4-bit countdown is enough.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Request fields captured on the accepting edge.
    typedef struct packed {
        logic                  rw;
        logic [DEPTH_LOG2-1:0] addr;
        logic [WIDTH-1:0]      din;
    } req_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_t             lat_req;
    logic [WIDTH-1:0] mem [DEPTH];

    // Handshake FSM, access engine, counters and memory array.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_req   <= '0;
            ackMEM    <= 1'b0;
            doutMEM   <= '0;
            busy      <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (reqMEM) begin
                        lat_req.rw   <= rwMEM;
                        lat_req.addr <= addrMEM;
                        lat_req.din  <= dinMEM;
                        cnt          <= CNT_W'(LATENCY - 1);
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end

                ACCESS: begin
                    // If req drops before ack, the error is flagged but the access still completes.
                    if (!reqMEM) begin
                        proto_err <= 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (lat_req.rw) begin
                            mem[lat_req.addr] <= lat_req.din;
                            wr_count          <= wr_count + 16'd1;
                        end else begin
                            doutMEM  <= mem[lat_req.addr];
                            rd_count <= rd_count + 16'd1;
                        end
                        ackMEM <= 1'b1;
                        state  <= ACK;
                    end
                end

                ACK: begin
                    if (!reqMEM) begin
                        ackMEM <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    ackMEM <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed testbench for mem_bank_responder (default parameters, LATENCY=2).
module tb_mem_bank_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqMEM;
    logic        rwMEM;
    logic [5:0]  addrMEM;
    logic [31:0] dinMEM;
    logic        ackMEM;
    logic [31:0] doutMEM;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    mem_bank_responder dut (
        .clk       (clk),
        .reset     (reset),
        .reqMEM    (reqMEM),
        .rwMEM     (rwMEM),
        .addrMEM   (addrMEM),
        .dinMEM    (dinMEM),
        .ackMEM    (ackMEM),
        .doutMEM   (doutMEM),
        .busy      (busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step until ack rises, bounded. n counts edges including the accepting one.
    task automatic wait_ack(output int n);
        n = 0;
        while (ackMEM !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ack_timeout", 32'(ackMEM), 32'd1);
    endtask

    // Run one complete handshake; returns doutMEM sampled while ack is high.
    task automatic do_access(input logic rw, input logic [5:0] a, input logic [31:0] d,
                             output logic [31:0] q, output int lat);
        int n;
        reqMEM  = 1'b1;
        rwMEM   = rw;
        addrMEM = a;
        dinMEM  = d;
        wait_ack(n);
        lat = n - 1;
        q = doutMEM;
        reqMEM = 1'b0;
        step();
        chk("ack_fall", 32'(ackMEM), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        reqMEM = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] q;
        int          lat;
        int          n;

        reset   = 1'b1;
        reqMEM  = 1'b0;
        rwMEM   = 1'b0;
        addrMEM = '0;
        dinMEM  = '0;

        // Reset, then idle for 10 cycles with all outputs low.
        do_reset();
        chk("rst_ack", 32'(ackMEM), 32'd0);
        chk("rst_dout", doutMEM, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(rd_count), 32'd0);
        chk("rst_wr", 32'(wr_count), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outs", {ackMEM, busy, proto_err, doutMEM, rd_count, wr_count} == '0 ? 32'd0 : 32'd1, 32'd0);
        end
        do_access(1'b0, 6'h3F, 32'h0, q, lat);
        chk("rd3f_data", q, 32'h0000_0000);

        // Write/read round trip.
        do_reset();
        reqMEM  = 1'b1;
        rwMEM   = 1'b1;
        addrMEM = 6'h05;
        dinMEM  = 32'hDEAD_BEEF;
        step();
        chk("wr_accept_busy", 32'(busy), 32'd1);
        chk("wr_accept_ack", 32'(ackMEM), 32'd0);
        step();
        chk("wr_e1_ack", 32'(ackMEM), 32'd0);
        step();
        chk("wr_e2_ack", 32'(ackMEM), 32'd1);
        reqMEM = 1'b0;
        step();
        chk("wr_ack_fall", 32'(ackMEM), 32'd0);
        do_access(1'b0, 6'h05, 32'h0, q, lat);
        chk("rt_rd_data", q, 32'hDEAD_BEEF);
        chk("rt_rd_lat", 32'(lat), 32'd2);
        chk("rt_wr_cnt", 32'(wr_count), 32'd1);
        chk("rt_rd_cnt", 32'(rd_count), 32'd1);

        // Handshake hold: req stays high for 5 extra cycles after ack.
        reqMEM  = 1'b1;
        rwMEM   = 1'b0;
        addrMEM = 6'h05;
        wait_ack(n);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_ack", 32'(ackMEM), 32'd1);
            chk("hold_dout", doutMEM, 32'hDEAD_BEEF);
        end
        chk("hold_rd_cnt", 32'(rd_count), 32'd2);
        reqMEM = 1'b0;
        step();
        chk("hold_ack_fall", 32'(ackMEM), 32'd0);
        chk("hold_rd_cnt2", 32'(rd_count), 32'd2);

        // Inputs changing during ACCESS are ignored.
        reqMEM  = 1'b1;
        rwMEM   = 1'b1;
        addrMEM = 6'h10;
        dinMEM  = 32'h1111_1111;
        step();
        addrMEM = 6'h11;
        dinMEM  = 32'h2222_2222;
        rwMEM   = 1'b0;
        wait_ack(n);
        reqMEM = 1'b0;
        step();
        chk("mid_wr_cnt", 32'(wr_count), 32'd2);
        do_access(1'b0, 6'h10, 32'h0, q, lat);
        chk("mid_rd10", q, 32'h1111_1111);
        do_access(1'b0, 6'h11, 32'h0, q, lat);
        chk("mid_rd11", q, 32'h0000_0000);
        chk("mid_rd_cnt", 32'(rd_count), 32'd4);
        chk("mid_perr", 32'(proto_err), 32'd0);

        // Early request drop: req falls one cycle after acceptance.
        reqMEM  = 1'b1;
        rwMEM   = 1'b0;
        addrMEM = 6'h10;
        step();
        chk("early_busy", 32'(busy), 32'd1);
        reqMEM = 1'b0;
        step();
        chk("early_perr", 32'(proto_err), 32'd1);
        chk("early_ack0", 32'(ackMEM), 32'd0);
        step();
        chk("early_ack1", 32'(ackMEM), 32'd1);
        chk("early_dout", doutMEM, 32'h1111_1111);
        chk("early_rd_cnt", 32'(rd_count), 32'd5);
        step();
        chk("early_ack_fall", 32'(ackMEM), 32'd0);
        chk("early_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("early_sticky", 32'(proto_err), 32'd1);
            chk("early_noack", 32'(ackMEM), 32'd0);
        end
        chk("early_rd_cnt2", 32'(rd_count), 32'd5);

        // Reset during ACCESS discards the write.
        do_reset();
        chk("perr_cleared", 32'(proto_err), 32'd0);
        reqMEM  = 1'b1;
        rwMEM   = 1'b1;
        addrMEM = 6'h2A;
        dinMEM  = 32'hCAFE_F00D;
        step();
        chk("mra_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk("mra_busy_rst", 32'(busy), 32'd0);
        chk("mra_ack_rst", 32'(ackMEM), 32'd0);
        reset  = 1'b0;
        reqMEM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mra_noack", 32'(ackMEM), 32'd0);
        end
        chk("mra_wr_cnt", 32'(wr_count), 32'd0);
        do_access(1'b0, 6'h2A, 32'h0, q, lat);
        chk("mra_rd2a", q, 32'h0000_0000);
        chk("mra_wr_cnt2", 32'(wr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
